uart_frame_ctrl: RTL and testbench

Host-link sequencer between the UART receiver/transmitter pair and the CNN inference core. Parses a framed image upload from the serial receiver, writes pixel bytes into the image buffer, pulses the core's start, waits for done, and returns the classification byte through the serial transmitter. It is the only master of the image-buffer write port and the only driver of the transmitter's byte interface.

---
 rtl/cnn_link_pkg.sv | 22 ++
 rtl/uart_frame_ctrl_byte_timeout.sv | 47 ++++
 rtl/uart_frame_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_link_pkg.sv
// Shared definitions for the host-link sequencer and its host-side models:
// state encoding, framing bytes and the running checksum helper.
package cnn_link_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RECV      = 3'd1,
        CHECK     = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        SEND      = 3'd5,
        WAIT_TX   = 3'd6
    } link_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ERR_BYTE  = 8'hEE;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/uart_frame_ctrl_byte_timeout.sv
// byte_timeout: inter-byte idle watchdog. Down-counter reloaded by i_clr,
// decremented by i_en, saturating at zero; o_tc flags the terminal count.
module byte_timeout #(
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] ZERO_VAL = {TW{1'b0}};
    localparam logic [TW-1:0] ONE_VAL  = TW'(1);

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;
    logic          r_tc;

    // Next count: reload wins over decrement; zero holds so the count never wraps.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = LOAD_VAL;
        end else if (i_en && (r_cnt != ZERO_VAL)) begin
            w_cnt_nxt = r_cnt - ONE_VAL;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Remaining-clocks register; reloaded value is the "zero idle clocks" point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= LOAD_VAL;
            r_tc  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_tc  <= (w_cnt_nxt == ZERO_VAL);
        end
    end

    assign o_tc = r_tc;

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses A5-framed image uploads into the image buffer, kicks
// the CNN core and returns its class byte. Optional trailing XOR checksum: FRAME_CHECKSUM_EN.
module uart_frame_ctrl
    import cnn_link_pkg::*;
#(
    parameter int IMG_BYTES    = 784,
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         rx_dv,
    input  logic [7:0]                   rx_byte,
    output logic                         tx_dv,
    output logic [7:0]                   tx_byte,
    input  logic                         tx_busy,
    output logic                         img_we,
    output logic [$clog2(IMG_BYTES)-1:0] img_addr,
    output logic [7:0]                   img_wdata,
    output logic                         start,
    input  logic                         done,
    input  logic [3:0]                   result,
    output logic                         busy,
    output logic                         err
);

    localparam int AW = $clog2(IMG_BYTES);
    localparam logic [AW-1:0] LAST_IDX = AW'(IMG_BYTES - 1);
    localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

`ifdef FRAME_CHECKSUM_EN
    localparam link_state_e PIX_DONE_ST = CHECK;
`else
    localparam link_state_e PIX_DONE_ST = START;
`endif

    link_state_e r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic          r_tx_skip, w_tx_skip_nxt;
    logic          r_tx_dv, w_tx_dv_nxt;
    logic [7:0]    r_tx_byte, w_tx_byte_nxt;
    logic          r_img_we, w_img_we_nxt;
    logic [AW-1:0] r_img_addr, w_img_addr_nxt;
    logic [7:0]    r_img_wdata, w_img_wdata_nxt;
    logic          r_start, w_start_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_err, w_err_nxt;
    logic          w_to_clr, w_to_en, w_to_tc;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    r_csum, w_csum_nxt;
`endif

    // Watchdog idles reloaded outside a frame and restarts on every received byte.
    assign w_to_clr = rx_dv || (r_state == IDLE);
    assign w_to_en  = (r_state == RECV) || (r_state == CHECK);

    byte_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_byte_timeout (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_clr   (w_to_clr),
        .i_en    (w_to_en),
        .o_tc    (w_to_tc)
    );

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_tx_skip_nxt   = r_tx_skip;
        w_tx_dv_nxt     = 1'b0;
        w_tx_byte_nxt   = r_tx_byte;
        w_img_we_nxt    = 1'b0;
        w_img_addr_nxt  = r_img_addr;
        w_img_wdata_nxt = r_img_wdata;
        w_start_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        w_csum_nxt      = r_csum;
`endif
        case (r_state)
            IDLE: begin
                if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                    w_state_nxt = RECV;
                    w_idx_nxt   = ZERO_IDX;
`ifdef FRAME_CHECKSUM_EN
                    w_csum_nxt  = 8'h00;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RECV: begin
                // A byte arriving on the terminal-count clock is still accepted.
                if (rx_dv) begin
                    w_img_we_nxt    = 1'b1;
                    w_img_addr_nxt  = r_idx;
                    w_img_wdata_nxt = rx_byte;
`ifdef FRAME_CHECKSUM_EN
                    w_csum_nxt      = csum_update(r_csum, rx_byte);
`endif
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = PIX_DONE_ST;
                    end else begin
                        w_idx_nxt = r_idx + ONE_IDX;
                    end
                end else if (w_to_tc) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RECV;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CHECK: begin
                if (rx_dv) begin
                    if (rx_byte == r_csum) begin
                        w_state_nxt = START;
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_tx_byte_nxt = ERR_BYTE;
                        w_state_nxt   = SEND;
                    end
                end else if (w_to_tc) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = CHECK;
                end
            end
`endif
            START: begin
                w_start_nxt = 1'b1;
                w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    w_tx_byte_nxt = {4'h0, result};
                    w_state_nxt   = SEND;
                end else begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    w_tx_dv_nxt   = 1'b1;
                    w_tx_skip_nxt = 1'b1;
                    w_state_nxt   = WAIT_TX;
                end else begin
                    w_state_nxt = SEND;
                end
            end
            WAIT_TX: begin
                // The transmitter raises tx_busy a clock late; ignore it on the first clock.
                if (r_tx_skip) begin
                    w_tx_skip_nxt = 1'b0;
                end else if (!tx_busy) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_TX;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // Sequencer state, pixel index and WAIT_TX first-clock flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_idx     <= ZERO_IDX;
            r_tx_skip <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_tx_skip <= w_tx_skip_nxt;
        end
    end

    // Registered outputs toward the buffer, core and transmitter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_img_we    <= 1'b0;
            r_img_addr  <= ZERO_IDX;
            r_img_wdata <= 8'h00;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_tx_dv     <= w_tx_dv_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_img_we    <= w_img_we_nxt;
            r_img_addr  <= w_img_addr_nxt;
            r_img_wdata <= w_img_wdata_nxt;
            r_start     <= w_start_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // Running XOR of the pixels of the current frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csum <= 8'h00;
        end else begin
            r_csum <= w_csum_nxt;
        end
    end
`endif

    assign tx_dv     = r_tx_dv;
    assign tx_byte   = r_tx_byte;
    assign img_we    = r_img_we;
    assign img_addr  = r_img_addr;
    assign img_wdata = r_img_wdata;
    assign start     = r_start;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed self-checking bench for uart_frame_ctrl (IMG_BYTES=4, TIMEOUT_CLKS=100)
// with a behavioural UART transmitter; follows FRAME_CHECKSUM_EN when defined.
module tb_uart_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_busy = 1'b0;
    logic       img_we;
    logic [1:0] img_addr;
    logic [7:0] img_wdata;
    logic       start;
    logic       done = 1'b0;
    logic [3:0] result = 4'h0;
    logic       busy;
    logic       err;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:3];
    logic [1:0] wr_log [$];
    int wr_cnt = 0, start_cnt = 0, err_cnt = 0, tx_cnt = 0;
    int tx_left = 0;
    logic [7:0] last_tx = 8'h00;
    int w0, s0, e0, t0, n;

    uart_frame_ctrl #(.IMG_BYTES(4), .TIMEOUT_CLKS(100)) dut (
        .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_busy(tx_busy),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .start(start), .done(done), .result(result), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Transmitter model: accepts tx_dv when idle, busy goes high the next clock for 4 clocks.
    always @(posedge clk) begin
        if (tx_dv && !tx_busy) begin
            tx_busy <= 1'b1;
            tx_left <= 3;
            last_tx <= tx_byte;
        end else if (tx_busy) begin
            if (tx_left == 0) tx_busy <= 1'b0;
            else tx_left <= tx_left - 1;
        end
    end

    // Event monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (img_we) begin
            mem[img_addr] = img_wdata;
            wr_log.push_back(img_addr);
            wr_cnt++;
        end
        if (start) start_cnt++;
        if (err) err_cnt++;
        if (tx_dv) tx_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv = 1'b1;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] p0, p1, p2, p3);
        send_byte(8'hA5);
        send_byte(p0);
        send_byte(p1);
        send_byte(p2);
        send_byte(p3);
`ifdef FRAME_CHECKSUM_EN
        send_byte(p0 ^ p1 ^ p2 ^ p3);
`endif
    endtask

    task automatic pulse_done(input logic [3:0] r);
        result = r;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return {9'd0, tx_dv, tx_byte, img_we, img_addr, img_wdata, start, busy, err};
    endfunction

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Clean frame
        w0 = wr_cnt; s0 = start_cnt; t0 = tx_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        check("busy_after_sync", {31'd0, busy}, 32'd1);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        send_byte(8'h40);
        check("last_pixel_write", {22'd0, img_we, img_addr, img_wdata}, {22'd0, 1'b1, 2'd3, 8'h40});
`ifdef FRAME_CHECKSUM_EN
        send_byte(8'h40);
`endif
        @(negedge clk);
        check("start_timing", {31'd0, start}, 32'd1);
        repeat (2) @(negedge clk);
        check("clean_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h10203040);
        check("clean_writes", wr_cnt - w0, 4);
        check("clean_start_cnt", start_cnt - s0, 1);
        pulse_done(4'h7);
        wait_idle("clean_idle");
        check("clean_tx_cnt", tx_cnt - t0, 1);
        check("clean_tx_byte", {24'd0, last_tx}, 32'h07);
        check("clean_no_err", err_cnt - e0, 0);

        // Junk before sync
        w0 = wr_cnt; t0 = tx_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_ignored", {busy, 31'd0} | (wr_cnt - w0), 32'd0);
        run_frame(8'h01, 8'h02, 8'h03, 8'h04);
        repeat (2) @(negedge clk);
        check("junk_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h01020304);
        check("junk_writes", wr_cnt - w0, 4);
        check("junk_first_addr", {30'd0, wr_log[w0]}, 32'd0);
        pulse_done(4'h3);
        wait_idle("junk_idle");
        check("junk_tx_byte", {24'd0, last_tx}, 32'h03);

        // Inter-byte timeout
        s0 = start_cnt; t0 = tx_cnt; e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        n = 0;
        while (err !== 1'b1 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, 100);
        @(negedge clk);
        check("timeout_idle", {30'd0, busy, err}, 32'd0);
        repeat (10) @(negedge clk);
        check("timeout_err_cnt", err_cnt - e0, 1);
        check("timeout_no_start", start_cnt - s0, 0);
        check("timeout_no_tx", tx_cnt - t0, 0);
        run_frame(8'h05, 8'h06, 8'h07, 8'h08);
        repeat (2) @(negedge clk);
        check("after_timeout_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h05060708);
        pulse_done(4'h9);
        wait_idle("after_timeout_idle");
        check("after_timeout_tx", {24'd0, last_tx}, 32'h09);

`ifdef FRAME_CHECKSUM_EN
        // Checksum good and bad
        s0 = start_cnt; e0 = err_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0F);
        repeat (2) @(negedge clk);
        check("csum_good_start", start_cnt - s0, 1);
        check("csum_good_no_err", err_cnt - e0, 0);
        pulse_done(4'h2);
        wait_idle("csum_good_idle");
        check("csum_good_tx", {24'd0, last_tx}, 32'h02);
        s0 = start_cnt; e0 = err_cnt; t0 = tx_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
        send_byte(8'h0E);
        check("csum_bad_err", {31'd0, err}, 32'd1);
        wait_idle("csum_bad_idle");
        check("csum_bad_tx", {24'd0, last_tx}, 32'hEE);
        check("csum_bad_tx_cnt", tx_cnt - t0, 1);
        check("csum_bad_no_start", start_cnt - s0, 0);
`endif

        // Reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", out_vec(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        w0 = wr_cnt;
        run_frame(8'h31, 8'h32, 8'h33, 8'h34);
        repeat (2) @(negedge clk);
        check("midreset_first_addr", {30'd0, wr_log[w0]}, 32'd0);
        check("midreset_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h31323334);
        pulse_done(4'h1);
        wait_idle("midreset_idle");
        check("midreset_tx", {24'd0, last_tx}, 32'h01);

        // Stray done in IDLE and stray byte in WAIT_DONE
        t0 = tx_cnt;
        pulse_done(4'h5);
        repeat (3) @(negedge clk);
        check("stray_done_idle", {busy, 31'd0} | (tx_cnt - t0), 32'd0);
        w0 = wr_cnt;
        run_frame(8'h41, 8'h42, 8'h43, 8'h44);
        repeat (3) @(negedge clk);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        check("stray_rx_no_write", wr_cnt - w0, 4);
        check("stray_rx_busy", {31'd0, busy}, 32'd1);
        check("stray_rx_no_tx", tx_cnt - t0, 0);
        pulse_done(4'hC);
        wait_idle("stray_idle");
        check("stray_tx", {24'd0, last_tx}, 32'h0C);
        check("stray_tx_cnt", tx_cnt - t0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
